// File: rtl/hc74_selftest_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hc74_selftest_ctrl
// Purpose  : Sequencer that exercises both channels of a 74-style dual D
//            flip-flop through a fixed 6-step preset/clear/clock/hold test,
//            compares Q/QN readback, and reports pass, the first failing
//            step and the set of failing channels.
// Revision : 1.0 - initial release
// ============================================================================
module hc74_selftest_ctrl (
  input  logic       Clk,
  input  logic       RD,
  input  logic       start,
  output logic [1:2] dut_D,
  output logic [1:2] dut_Clk,
  output logic [1:2] dut_SD,
  output logic [1:2] dut_RD,
  input  logic [1:2] dut_Q,
  input  logic [1:2] dut_QN,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_step,
  output logic [1:2] fail_mask
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_EDGE_HI = 3'd2,
    S_EDGE_LO = 3'd3,
    S_SAMPLE  = 3'd4,
    S_NEXT    = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  localparam logic [2:0] LAST_STEP = 3'd5;
  localparam logic [2:0] NO_FAIL   = 3'd7;

  // Step stimulus: {SD, RD, D1, clocked}. Channel 2 D is always ~D1.
  function automatic logic [3:0] step_drive(input logic [2:0] s);
    logic [3:0] cfg;
    case (s)
      3'd0:    cfg = 4'b0100;  // preset
      3'd1:    cfg = 4'b1010;  // clear
      3'd2:    cfg = 4'b1111;  // clock in D1=1
      3'd3:    cfg = 4'b1101;  // clock in D1=0
      3'd4:    cfg = 4'b1110;  // D changes, no edge: hold
      3'd5:    cfg = 4'b0000;  // preset and clear together
      default: cfg = 4'b1100;  // inactive drive
    endcase
    return cfg;
  endfunction

  // Expected Q per channel {Q1, Q2}; QN is always checked as the inverse.
  function automatic logic [1:2] step_expect(input logic [2:0] s);
    logic [1:2] q;
    case (s)
      3'd0:    q = 2'b11;
      3'd1:    q = 2'b00;
      3'd2:    q = 2'b10;
      3'd3:    q = 2'b01;
      3'd4:    q = 2'b01;
      3'd5:    q = 2'b11;
      default: q = 2'b00;
    endcase
    return q;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       sub_q, sub_d;          // second cycle of a two-cycle phase
  logic       pass_q, pass_d;
  logic [2:0] fail_step_q, fail_step_d;
  logic [1:2] fail_mask_q, fail_mask_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:2] drv_d_q, drv_d_d;
  logic [1:2] drv_clk_q, drv_clk_d;
  logic [1:2] drv_sd_q, drv_sd_d;
  logic [1:2] drv_rd_q, drv_rd_d;

  logic [1:2] exp_q;
  logic [1:2] mismatch;
  logic       run_d;
  logic [3:0] cfg_d;

  assign exp_q    = step_expect(step_q);
  assign mismatch = (dut_Q ^ exp_q) | (dut_QN ^ ~exp_q);

  // Next-state, step sequencing and result accumulation.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    sub_d       = sub_q;
    pass_d      = pass_q;
    fail_step_d = fail_step_q;
    fail_mask_d = fail_mask_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_APPLY;
          step_d      = 3'd0;
          sub_d       = 1'b0;
          pass_d      = 1'b0;
          fail_step_d = NO_FAIL;
          fail_mask_d = 2'b00;
        end
      end
      S_APPLY: begin
        if (sub_q) begin
          state_d = S_EDGE_HI;
          sub_d   = 1'b0;
        end else begin
          sub_d = 1'b1;
        end
      end
      S_EDGE_HI: begin
        if (sub_q) begin
          state_d = S_EDGE_LO;
          sub_d   = 1'b0;
        end else begin
          sub_d = 1'b1;
        end
      end
      S_EDGE_LO: begin
        if (sub_q) begin
          state_d = S_SAMPLE;
          sub_d   = 1'b0;
        end else begin
          sub_d = 1'b1;
        end
      end
      S_SAMPLE: begin
        state_d     = S_NEXT;
        fail_mask_d = fail_mask_q | mismatch;
        if ((mismatch != 2'b00) && (fail_step_q == NO_FAIL)) begin
          fail_step_d = step_q;
        end
      end
      S_NEXT: begin
        if (step_q == LAST_STEP) begin
          state_d = S_FINISH;
          pass_d  = (fail_mask_q == 2'b00);
        end else begin
          state_d = S_APPLY;
          step_d  = step_q + 3'd1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        step_d  = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 3'd0;
        sub_d   = 1'b0;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so the
  // registered outputs line up exactly with the state they belong to.
  always_comb begin
    run_d     = 1'b0;
    cfg_d     = step_drive(step_d);
    busy_d    = 1'b0;
    done_d    = (state_d == S_FINISH);
    drv_d_d   = 2'b00;
    drv_clk_d = 2'b00;
    drv_sd_d  = 2'b11;
    drv_rd_d  = 2'b11;
    case (state_d)
      S_APPLY, S_EDGE_HI, S_EDGE_LO, S_SAMPLE, S_NEXT: run_d = 1'b1;
      default:                                          run_d = 1'b0;
    endcase
    if (run_d) begin
      busy_d   = 1'b1;
      drv_d_d  = {cfg_d[1], ~cfg_d[1]};
      drv_sd_d = {cfg_d[3], cfg_d[3]};
      drv_rd_d = {cfg_d[2], cfg_d[2]};
      if ((state_d == S_EDGE_HI) && cfg_d[0]) begin
        drv_clk_d = 2'b11;
      end
    end
  end

  // Control state and results; reset forces idle and "no failure".
  always_ff @(posedge Clk or negedge RD) begin
    if (!RD) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      sub_q       <= 1'b0;
      pass_q      <= 1'b0;
      fail_step_q <= NO_FAIL;
      fail_mask_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      sub_q       <= sub_d;
      pass_q      <= pass_d;
      fail_step_q <= fail_step_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  // Registered status and device drive; reset forces the idle drive.
  always_ff @(posedge Clk or negedge RD) begin
    if (!RD) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drv_d_q   <= 2'b00;
      drv_clk_q <= 2'b00;
      drv_sd_q  <= 2'b11;
      drv_rd_q  <= 2'b11;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      drv_d_q   <= drv_d_d;
      drv_clk_q <= drv_clk_d;
      drv_sd_q  <= drv_sd_d;
      drv_rd_q  <= drv_rd_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_step = fail_step_q;
  assign fail_mask = fail_mask_q;
  assign dut_D     = drv_d_q;
  assign dut_Clk   = drv_clk_q;
  assign dut_SD    = drv_sd_q;
  assign dut_RD    = drv_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_hc74_selftest_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hc74_selftest_ctrl
// Purpose  : Self-checking bench for hc74_selftest_ctrl with a behavioural
//            dual flip-flop device model, fault injection and a step-level
//            reference model of the expected run result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hc74_selftest_ctrl;

  localparam int M_GOOD   = 0;  // well-behaved device
  localparam int M_STUCK  = 1;  // channel 2 Q stuck at 0
  localparam int M_CLRDOM = 2;  // clear wins when SD=RD=0

  logic       Clk = 1'b0;
  logic       RD;
  logic       start;
  logic [1:2] dut_D, dut_Clk, dut_SD, dut_RD;
  logic [1:2] dut_Q, dut_QN;
  logic       busy, done, pass;
  logic [2:0] fail_step;
  logic [1:2] fail_mask;

  int vectors    = 0;
  int miscompares = 0;

  int         mode     = M_GOOD;
  int         cur_step = 7;
  logic [1:2] cq  [6];
  logic [1:2] cqn [6];
  logic       ff1 = 1'b0;
  logic       ff2 = 1'b0;

  // Step table as written in the test plan: SD, RD, D1, clocked, expected Q1.
  bit tb_sd  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit tb_rd  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  bit tb_d1  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  bit tb_clk [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  bit tb_q1  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  hc74_selftest_ctrl u_dut (
    .Clk       (Clk),
    .RD        (RD),
    .start     (start),
    .dut_D     (dut_D),
    .dut_Clk   (dut_Clk),
    .dut_SD    (dut_SD),
    .dut_RD    (dut_RD),
    .dut_Q     (dut_Q),
    .dut_QN    (dut_QN),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_step (fail_step),
    .fail_mask (fail_mask)
  );

  always #5 Clk = ~Clk;

  // Device model, channel 1: async preset/clear, rising-edge D capture.
  always @(posedge dut_Clk[1] or negedge dut_SD[1] or negedge dut_RD[1]) begin
    if (mode == M_CLRDOM && !dut_RD[1]) ff1 <= 1'b0;
    else if (!dut_SD[1])                ff1 <= 1'b1;
    else if (!dut_RD[1])                ff1 <= 1'b0;
    else                                ff1 <= dut_D[1];
  end

  // Device model, channel 2.
  always @(posedge dut_Clk[2] or negedge dut_SD[2] or negedge dut_RD[2]) begin
    if (mode == M_CLRDOM && !dut_RD[2]) ff2 <= 1'b0;
    else if (!dut_SD[2])                ff2 <= 1'b1;
    else if (!dut_RD[2])                ff2 <= 1'b0;
    else                                ff2 <= dut_D[2];
  end

  // Readback with stuck-at and per-step corruption applied.
  always_comb begin
    dut_Q  = {ff1, ff2};
    dut_QN = {~ff1, ~ff2};
    if (mode == M_STUCK) dut_Q[2] = 1'b0;
    if (cur_step >= 0 && cur_step < 6) begin
      dut_Q  = dut_Q ^ cq[cur_step];
      dut_QN = dut_QN ^ cqn[cur_step];
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic clear_faults();
    for (int s = 0; s < 6; s++) begin
      cq[s]  = 2'b00;
      cqn[s] = 2'b00;
    end
  endtask

  // Expected {pass, fail_step, fail_mask} from the step rules and fault set.
  function automatic logic [5:0] ref_result(input int m);
    logic [2:0] fstep;
    logic [1:2] fmask;
    logic       eq, aq, aqn;
    fstep = 3'd7;
    fmask = 2'b00;
    for (int s = 0; s < 6; s++) begin
      for (int k = 1; k <= 2; k++) begin
        eq = tb_q1[s];
        if (k == 2 && s >= 2 && s <= 4) eq = ~eq;
        aq  = eq;
        aqn = ~eq;
        if (m == M_STUCK && k == 2) aq = 1'b0;
        if (m == M_CLRDOM && s == 5) begin
          aq  = 1'b0;
          aqn = 1'b1;
        end
        aq  = aq ^ cq[s][k];
        aqn = aqn ^ cqn[s][k];
        if (aq != eq || aqn != ~eq) begin
          if (k == 1) fmask[1] = 1'b1;
          else        fmask[2] = 1'b1;
          if (fstep == 3'd7) fstep = 3'(s);
        end
      end
    end
    return {(fmask == 2'b00), fstep, fmask};
  endfunction

  // Walks the 48 busy cycles, FINISH and the following idle cycle.
  // Entry: start has been accepted, next negedge is busy cycle 1.
  task automatic run_body(input bit hold, input bit rand_start, input logic exp_pass,
                          input logic [2:0] exp_step, input logic [1:2] exp_mask,
                          input string tag);
    int s, ph;
    logic [7:0] exp_drv;
    for (int c = 1; c <= 48; c++) begin
      @(negedge Clk);
      s = (c - 1) / 8;
      ph = (c - 1) % 8;
      cur_step = s;
      if (hold)            start = 1'b1;
      else if (rand_start) start = 1'($urandom_range(0, 1));
      else                 start = 1'b0;
      exp_drv = {tb_d1[s], ~tb_d1[s],
                 (tb_clk[s] && (ph == 2 || ph == 3)) ? 2'b11 : 2'b00,
                 tb_sd[s], tb_sd[s], tb_rd[s], tb_rd[s]};
      check({tag, " drive"}, {dut_D, dut_Clk, dut_SD, dut_RD}, exp_drv);
      check({tag, " busy/done"}, {6'd0, busy, done}, 8'b10);
      if (c == 1) check({tag, " cleared at start"}, {3'd0, fail_step, fail_mask}, {3'd0, 3'd7, 2'b00});
    end
    @(negedge Clk);
    cur_step = 7;
    start = hold;
    check({tag, " finish busy/done"}, {6'd0, busy, done}, 8'b01);
    check({tag, " result"}, {2'd0, pass, fail_step, fail_mask}, {2'd0, exp_pass, exp_step, exp_mask});
    check({tag, " finish drive"}, {dut_D, dut_Clk, dut_SD, dut_RD}, 8'h0F);
    @(negedge Clk);
    check({tag, " idle busy/done"}, {6'd0, busy, done}, 8'b00);
    check({tag, " result held"}, {2'd0, pass, fail_step, fail_mask}, {2'd0, exp_pass, exp_step, exp_mask});
  endtask

  task automatic do_run(input bit rand_start, input logic [5:0] exp, input string tag);
    @(negedge Clk);
    start = 1'b1;
    run_body(1'b0, rand_start, exp[5], exp[4:2], exp[1:0], tag);
  endtask

  typedef struct {
    int         mode;
    logic       exp_pass;
    logic [2:0] exp_step;
    logic [1:2] exp_mask;
    string      tag;
  } run_vec_t;

  run_vec_t vecs [4];

  initial begin
    logic [5:0] exp;

    vecs[0].mode = M_GOOD;   vecs[0].exp_pass = 1'b1; vecs[0].exp_step = 3'd7; vecs[0].exp_mask = 2'b00; vecs[0].tag = "good";
    vecs[1].mode = M_STUCK;  vecs[1].exp_pass = 1'b0; vecs[1].exp_step = 3'd0; vecs[1].exp_mask = 2'b01; vecs[1].tag = "stuck_q2";
    vecs[2].mode = M_CLRDOM; vecs[2].exp_pass = 1'b0; vecs[2].exp_step = 3'd5; vecs[2].exp_mask = 2'b11; vecs[2].tag = "clr_dom";
    vecs[3].mode = M_GOOD;   vecs[3].exp_pass = 1'b1; vecs[3].exp_step = 3'd7; vecs[3].exp_mask = 2'b00; vecs[3].tag = "good_again";

    clear_faults();
    RD = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset status", {busy, done, pass, fail_step, fail_mask}, {3'b000, 3'd7, 2'b00});
    check("reset drive", {dut_D, dut_Clk, dut_SD, dut_RD}, 8'h0F);
    start = 1'b0;
    RD = 1'b1;
    @(negedge Clk);
    check("idle after reset", {6'd0, busy, done}, 8'b00);

    // Table-driven full runs.
    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      clear_faults();
      do_run(1'b0, {vecs[i].exp_pass, vecs[i].exp_step, vecs[i].exp_mask}, vecs[i].tag);
    end

    // start held across a whole run: one run, then a new one right after IDLE.
    mode = M_GOOD;
    @(negedge Clk);
    start = 1'b1;
    run_body(1'b1, 1'b0, 1'b1, 3'd7, 2'b00, "hold_run1");
    run_body(1'b0, 1'b0, 1'b1, 3'd7, 2'b00, "hold_run2");

    // Reset pulsed mid-run during a failing run.
    mode = M_STUCK;
    @(negedge Clk);
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      start = 1'b0;
      cur_step = (c - 1) / 8;
    end
    check("pre-reset fail_step", {5'd0, fail_step}, 8'd0);
    RD = 1'b0;
    #1;
    cur_step = 7;
    check("midrun reset status", {busy, done, pass, fail_step, fail_mask}, {3'b000, 3'd7, 2'b00});
    check("midrun reset drive", {dut_D, dut_Clk, dut_SD, dut_RD}, 8'h0F);
    @(negedge Clk);
    RD = 1'b1;
    mode = M_GOOD;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      check("no done after abort", {6'd0, busy, done}, 8'b00);
    end

    // start accepted on the first edge after reset release.
    @(negedge Clk);
    RD = 1'b0;
    @(negedge Clk);
    RD = 1'b1;
    start = 1'b1;
    run_body(1'b0, 1'b0, 1'b1, 3'd7, 2'b00, "post_reset");

    // Randomized fault patterns with start toggling during the run.
    for (int r = 0; r < 10; r++) begin
      mode = int'($urandom_range(0, 2));
      for (int s = 0; s < 6; s++) begin
        for (int k = 1; k <= 2; k++) begin
          cq[s][k]  = ($urandom_range(0, 11) == 0);
          cqn[s][k] = ($urandom_range(0, 11) == 0);
        end
      end
      exp = ref_result(mode);
      do_run(1'b1, exp, $sformatf("random%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", vectors);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/hc74_selftest_ctrl.md
HC74_SELFTEST_CTRL -- requirements
Module: hc74_selftest_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1, single system clock; all state rises on posedge Clk.
REQ-002 SHALL have port RD, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-004 SHALL have port dut_D, output, [1:2], D drive to both flip-flop channels.
REQ-005 SHALL have port dut_Clk, output, [1:2], clock drive to both channels.
REQ-006 SHALL have port dut_SD, output, [1:2], active-low preset drive.
REQ-007 SHALL have port dut_RD, output, [1:2], active-low clear drive.
REQ-008 SHALL have port dut_Q, input, [1:2], channel Q readback.
REQ-009 SHALL have port dut_QN, input, [1:2], channel QN readback.
REQ-010 SHALL have port busy, output, 1, high while a run is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at the end of a run.
REQ-012 SHALL have port pass, output, 1, result of the last run.
REQ-013 SHALL have port fail_step, output, [2:0], index of the first failing step; 3'd7 means none.
REQ-014 SHALL have port fail_mask, output, [1:2], channels that failed any step.

Function
REQ-015 SHALL use these FSM states: IDLE, APPLY, EDGE_HI, EDGE_LO, SAMPLE, NEXT, FINISH.
REQ-016 SHALL in IDLE, on start=1, clear fail_mask, set fail_step=7, set step=0 and go to APPLY; busy=1 from the next cycle.
REQ-017 SHALL spend exactly 8 Clk cycles per step: APPLY 2, EDGE_HI 2, EDGE_LO 2, SAMPLE 1, NEXT 1.
REQ-018 SHALL apply the step's dut_D, dut_SD and dut_RD on entry to APPLY and hold them until NEXT completes.
REQ-019 SHALL keep dut_Clk low in APPLY and EDGE_LO; in EDGE_HI, dut_Clk=2'b11 only for clocked steps, otherwise low.
REQ-020 SHALL drive channel 2 D as the inverse of channel 1 D in every step.
REQ-021 SHALL implement this step table (SD,RD,D1,clocked -> expected Q1,QN1):
 - step 0: 0,1,0,no -> Q=1, QN=0 (preset).
 - step 1: 1,0,1,no -> Q=0, QN=1 (clear).
 - step 2: 1,1,1,yes -> Q=1.
 - step 3: 1,1,0,yes -> Q=0.
 - step 4: 1,1,1,no -> Q=0 (hold).
 - step 5: 0,0,0,no -> Q=1, QN=0 (preset dominates).
REQ-022 SHALL derive channel 2 expected values as follows: steps 0, 1 and 5 identical to channel 1; steps 2-4 expected Q2 = NOT Q1-expected.
REQ-023 SHALL always check QN as NOT Q-expected.
REQ-024 SHALL in SAMPLE compare dut_Q and dut_QN per channel; on mismatch, OR the channel into fail_mask, and load fail_step with step only if fail_step=7.
REQ-025 SHALL continue the run after a mismatch; no early abort.
REQ-026 SHALL in NEXT, if step=5, go to FINISH; otherwise increment step and go to APPLY.
REQ-027 SHALL in FINISH drive busy=0, done=1 for one cycle, pass=(fail_mask==0), restore idle drive and return to IDLE.
REQ-028 SHALL hold busy high for exactly 48 cycles; done goes high in the cycle immediately after busy falls.
REQ-029 SHALL ignore start while busy, with no restart and no queueing.
REQ-030 SHALL hold pass, fail_step and fail_mask from FINISH until the next accepted start.
REQ-031 SHALL use idle drive dut_D=00, dut_Clk=00, dut_SD=11, dut_RD=11.

Reset
REQ-032 SHALL, while RD=0, force immediately and asynchronously: state=IDLE, step=0, busy=0, done=0, pass=0, fail_step=7, fail_mask=00, dut outputs at idle drive.
REQ-033 SHALL, when RD is asserted mid-run, abandon the run; no done pulse is produced.
REQ-034 SHALL resume on the first posedge Clk after RD deasserts, accepting start on that edge.

Verification
REQ-035 SHALL cover: good DUT model, start pulse -> busy for 48 cycles, done pulse, pass=1, fail_step=7, fail_mask=00.
REQ-036 SHALL cover: channel 2 Q stuck at 0 -> pass=0, fail_step=0, fail_mask=2'b01 (bit 2 set).
REQ-037 SHALL cover: DUT with clear dominating at SD=RD=0 -> pass=0, fail_step=5, fail_mask=2'b11.
REQ-038 SHALL cover: start held high across the whole run -> exactly one run; next run starts the cycle after FINISH.
REQ-039 SHALL cover: RD pulsed low at cycle 20 of a run -> outputs at reset values within the same cycle, no done; a later start gives a full 48-cycle run.
REQ-040 SHALL cover: waveform check of step 2 -> dut_Clk=11 for exactly 2 cycles, D stable from 2 cycles before the rising edge through SAMPLE.
